// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: latches sector read/write requests from CHANNELS block
// devices and serialises them, round-robin, onto the per-channel
// sd_rd/sd_wr/sd_ack handshake of the HPS SD interface. cpu_wait is held
// while any channel has pending or in-service work.
//
// Optional feature macro: SD_ARB_TIMEOUT_EN (ISSUE/XFER watchdog, err pulses).
//
// Ports:
//   clk_sys, reset_n  clock, asynchronous active-low reset
//   req_rd, req_wr    one-cycle read/write request pulse per channel
//   req_lba           packed sector address, channel i at [i*LBA_W +: LBA_W]
//   ch_mounted        image mounted per channel
//   sd_ack            SD interface acknowledge per channel
//   sd_rd, sd_wr      read/write strobes to SD interface
//   sd_lba            sector address of the issued op per channel
//   grant             one-hot channel in service, zero when idle
//   ch_busy, cpu_wait channel has work / OR of ch_busy
//   done, err         one-cycle completion / timeout pulses
module sd_block_arbiter #(
  parameter int unsigned CHANNELS       = 3,
  parameter int unsigned LBA_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       req_rd,
  input  logic [CHANNELS-1:0]       req_wr,
  input  logic [CHANNELS*LBA_W-1:0] req_lba,
  input  logic [CHANNELS-1:0]       ch_mounted,
  input  logic [CHANNELS-1:0]       sd_ack,
  output logic [CHANNELS-1:0]       sd_rd,
  output logic [CHANNELS-1:0]       sd_wr,
  output logic [CHANNELS*LBA_W-1:0] sd_lba,
  output logic [CHANNELS-1:0]       grant,
  output logic [CHANNELS-1:0]       ch_busy,
  output logic                      cpu_wait,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       err
);

  localparam int unsigned PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2
  } state_e;

  // Reject configurations outside the supported range at elaboration.
  if (CHANNELS < 1 || CHANNELS > 10 || LBA_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sd_block_arbiter: parameter out of range");
  end

  state_e                      state_q, state_d;
  logic [CHANNELS-1:0]         pend_rd_q, pend_rd_d;
  logic [CHANNELS-1:0]         pend_wr_q, pend_wr_d;
  logic [CHANNELS*LBA_W-1:0]   lba_q, lba_d;
  logic [CHANNELS*LBA_W-1:0]   sd_lba_q, sd_lba_d;
  logic [CHANNELS-1:0]         sd_rd_q, sd_rd_d;
  logic [CHANNELS-1:0]         sd_wr_q, sd_wr_d;
  logic [CHANNELS-1:0]         grant_q, grant_d;
  logic [CHANNELS-1:0]         ch_busy_q, ch_busy_d;
  logic                        cpu_wait_q, cpu_wait_d;
  logic [CHANNELS-1:0]         done_q, done_d;
  logic [CHANNELS-1:0]         ack_q;
  logic [PTR_W-1:0]            rr_q, rr_d;
  logic [PTR_W-1:0]            cur_q, cur_d;
  logic                        cur_wr_q, cur_wr_d;

  logic                        sel_found;
  logic [PTR_W-1:0]            sel_idx;
  logic [PTR_W-1:0]            cidx;
  int unsigned                 cand;
  logic                        ack_rise;
  logic                        ack_fall;
  logic [PTR_W-1:0]            rr_next;

  // Edges of the granted channel's ack only; other channels' acks are ignored.
  assign ack_rise = sd_ack[cur_q] & ~ack_q[cur_q];
  assign ack_fall = ~sd_ack[cur_q] & ack_q[cur_q];
  assign rr_next  = (cur_q == PTR_W'(CHANNELS - 1)) ? '0 : cur_q + PTR_W'(1);

`ifdef SD_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] err_q, err_d;
  logic                tmo_hit;
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Round-robin search: first pending channel at or above rr_q, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      cidx = PTR_W'(cand);
      if (!sel_found && (pend_rd_q[cidx] || pend_wr_q[cidx])) begin
        sel_found = 1'b1;
        sel_idx   = cidx;
      end
    end
  end

  // Next-state, pend bookkeeping and output next values.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    pend_wr_d = pend_wr_q;
    lba_d     = lba_q;
    sd_lba_d  = sd_lba_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    grant_d   = grant_q;
    done_d    = '0;
    rr_d      = rr_q;
    cur_d     = cur_q;
    cur_wr_d  = cur_wr_q;
`ifdef SD_ARB_TIMEOUT_EN
    err_d     = '0;
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d  = CHANNELS'(1) << sel_idx;
          cur_d    = sel_idx;
          sd_lba_d[32'(sel_idx)*LBA_W +: LBA_W] = lba_q[32'(sel_idx)*LBA_W +: LBA_W];
          // Read before write when both are pending.
          if (pend_rd_q[sel_idx]) begin
            sd_rd_d[sel_idx] = 1'b1;
            cur_wr_d         = 1'b0;
          end else begin
            sd_wr_d[sel_idx] = 1'b1;
            cur_wr_d         = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ack_rise) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          if (cur_wr_q) pend_wr_d[cur_q] = 1'b0;
          else          pend_rd_d[cur_q] = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (ack_fall) begin
          done_d[cur_q] = 1'b1;
          rr_d          = rr_next;
          grant_d       = '0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SD_ARB_TIMEOUT_EN
    // Watchdog abort when no handshake progress was made this cycle.
    if (state_q != IDLE && state_d == state_q && tmo_hit) begin
      sd_rd_d = '0;
      sd_wr_d = '0;
      if (state_q == ISSUE) begin
        if (cur_wr_q) pend_wr_d[cur_q] = 1'b0;
        else          pend_rd_d[cur_q] = 1'b0;
      end
      err_d[cur_q] = 1'b1;
      rr_d         = rr_next;
      grant_d      = '0;
      state_d      = IDLE;
    end
    if (state_d != state_q)   cnt_d = '0;
    else if (state_q != IDLE) cnt_d = cnt_q + CNT_W'(1);
`endif

    // New requests win over a same-edge clear; unmounted channels hold nothing.
    pend_rd_d = (pend_rd_d | (req_rd & ch_mounted)) & ch_mounted;
    pend_wr_d = (pend_wr_d | (req_wr & ch_mounted)) & ch_mounted;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if ((req_rd[i] || req_wr[i]) && ch_mounted[i]) begin
        lba_d[i*LBA_W +: LBA_W] = req_lba[i*LBA_W +: LBA_W];
      end
    end

    ch_busy_d  = pend_rd_d | pend_wr_d | grant_d;
    cpu_wait_d = |ch_busy_d;
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      lba_q      <= '0;
      sd_lba_q   <= '0;
      sd_rd_q    <= '0;
      sd_wr_q    <= '0;
      grant_q    <= '0;
      ch_busy_q  <= '0;
      cpu_wait_q <= 1'b0;
      done_q     <= '0;
      ack_q      <= '0;
      rr_q       <= '0;
      cur_q      <= '0;
      cur_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
      lba_q      <= lba_d;
      sd_lba_q   <= sd_lba_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      grant_q    <= grant_d;
      ch_busy_q  <= ch_busy_d;
      cpu_wait_q <= cpu_wait_d;
      done_q     <= done_d;
      ack_q      <= sd_ack;
      rr_q       <= rr_d;
      cur_q      <= cur_d;
      cur_wr_q   <= cur_wr_d;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  // Watchdog counter and err pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = '0;
`endif

  assign sd_rd    = sd_rd_q;
  assign sd_wr    = sd_wr_q;
  assign sd_lba   = sd_lba_q;
  assign grant    = grant_q;
  assign ch_busy  = ch_busy_q;
  assign cpu_wait = cpu_wait_q;
  assign done     = done_q;

endmodule

// File: doc/sd_block_arbiter.md
# sd_block_arbiter

Multi-channel successor to the single-drive HDD request latch. It accepts sector read and write requests from up to CHANNELS block devices (floppy, HDD, spare), latches them, and serialises them onto the per-channel sd_rd/sd_wr/sd_ack handshake. Arbitration is round-robin. The block holds cpu_wait while any channel has work outstanding. It sits between the core (top) and the HPS SD interface in emu.

## Interface
- CHANNELS, 3, number of block channels (1..10, matching sd_rd width)
- LBA_W, 32, sector address width per channel
- TIMEOUT_CYCLES, 1048576, watchdog limit in clk_sys cycles (used only with SD_ARB_TIMEOUT_EN)

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_rd  in  CHANNELS  one-cycle read request pulse per channel
- req_wr  in  CHANNELS  one-cycle write request pulse per channel
- req_lba  in  CHANNELS*LBA_W  packed sector address; channel i occupies [i*LBA_W +: LBA_W]
- ch_mounted  in  CHANNELS  image mounted per channel
- sd_ack  in  CHANNELS  SD interface acknowledge per channel
- sd_rd  out  CHANNELS  read strobe to SD interface
- sd_wr  out  CHANNELS  write strobe to SD interface
- sd_lba  out  CHANNELS*LBA_W  latched sector address per channel
- grant  out  CHANNELS  one-hot channel in service, all-zero when idle
- ch_busy  out  CHANNELS  channel has a pending or in-service operation
- cpu_wait  out  1  OR of ch_busy
- done  out  CHANNELS  one-cycle completion pulse
- err  out  CHANNELS  one-cycle timeout pulse

## Operation
- Per channel: pend_rd, pend_wr, lba register.
  - req_rd/req_wr set the pend bit and load lba from req_lba on the same edge.
  - Requests to a channel with ch_mounted=0 are dropped: no pend, no done.
  - A later request overwrites the lba of a not-yet-issued op.
- ch_mounted falling clears that channel's pend bits. An op already in service completes normally.
- FSM states:
  - IDLE: select the first channel with pend_rd|pend_wr, searching from rr_ptr upward and wrapping. Load grant. If pend_rd, assert sd_rd[ch]; otherwise assert sd_wr[ch]. Go to ISSUE.
  - ISSUE: wait for the sd_ack[ch] rising edge, detected as sd_ack & ~ack_q with ack_q registered. On it, deassert sd_rd/sd_wr and clear the pend bit of the issued op. Go to XFER.
  - XFER: wait for the sd_ack[ch] falling edge. On it, pulse done[ch], set rr_ptr=ch+1 (wrap to 0 after CHANNELS-1), clear grant, and go to IDLE.
- Read before write: if both pend bits are set, read is issued first. Write stays pending and is served in a later grant, subject to round-robin.
- A request arriving on the same edge that clears that pend bit wins: the bit stays set.
- sd_ack on non-granted channels is ignored.
- ch_busy[i] = pend_rd|pend_wr|grant[i].

## Timing
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, grant=0, ch_busy=0, cpu_wait=0, done=0, err=0, rr_ptr=0, FSM=IDLE, ack_q=0.
- Reset takes effect asynchronously, mid-operation included. All pending work is discarded.
- Request pulse sampled at edge t:
  - ch_busy and cpu_wait high after t.
  - sd_rd/sd_wr high after t+1, if the FSM is IDLE and the channel wins arbitration.
- sd_ack rising sampled at edge k: sd_rd/sd_wr low after k.
- sd_ack falling sampled at edge m: done high for the cycle after m; grant=0 and cpu_wait low after m unless other work is pending.
- Back-to-back: the next grant issues on edge m+1. Minimum idle gap is one cycle.
- sd_lba[ch] is stable from issue until done.

## Configuration
- SD_ARB_TIMEOUT_EN defined:
  - A counter runs in ISSUE and XFER and resets on each state entry.
  - At TIMEOUT_CYCLES it deasserts sd_rd/sd_wr, clears the in-service pend bit, pulses err[ch], sets rr_ptr=ch+1, and returns to IDLE. No done pulse is issued.
- SD_ARB_TIMEOUT_EN undefined: no counter, err tied to 0, and the FSM waits indefinitely for sd_ack.

## Test plan
- Single read, ch1 mounted, req_lba=0x1234:
  - sd_rd=3'b010 two cycles after req and sd_lba[1]=0x1234.
  - Ack high 3 cycles, then low: sd_rd drops the cycle after ack high, done[1] pulses once, cpu_wait low.
- Simultaneous req_rd on ch0, ch1, ch2 after reset: grants are ch0, ch1, ch2 in order. A second burst starting with ch2 pending while rr_ptr=1 serves ch1 before ch2.
- ch0 req_rd and req_wr in the same cycle: sd_rd[0] completes first, then sd_wr[0] is issued, giving two done[0] pulses.
- req_rd on ch2 with ch_mounted[2]=0: sd_rd stays 0, ch_busy[2]=0, no done.
- reset_n low for 1 cycle while in XFER: all outputs zero immediately. A subsequent ack fall produces no done.
- With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack: err[0] pulses 16 cycles after issue, sd_rd[0]=0, FSM returns to IDLE. Without the macro, sd_rd[0] stays high for 1000 cycles.
